semiauto_nav: RTL
=================

// Module: semiauto_nav
// PURPOSE
//  Parametrised semi-automatic driving controller for the car. Drives forward until
//  the detector array reports a crossroad, stops, and waits for a user direction
//  command. It then performs a timed left, right or U-turn, or goes straight, followed
//  by a cooldown phase in which the crossroad is ignored so the car clears the junction.
//  Sits between the divclk-driven top level and the motor/light drivers.
//  Active only in semi-auto modes.
// PARAMETERS
//  DET_W       4        detector bus width
//  DET_IDLE    4'b0110  detector value on a plain track (per-bit expected level)
//  DET_MASK    4'b0111  bits that take part in crossroad detection
//  TURN_CYC    1000     sys_clk cycles for a 90-degree turn (U-turn = 2*TURN_CYC)
//  COOL_CYC    1000     sys_clk cycles of forced forward motion after a decision
//  WAIT_TO     5000     auto-straight timeout in WAIT (only with the optional feature)
//  CNT_W       16       counter width; must hold 2*TURN_CYC, COOL_CYC and WAIT_TO
// PORTS
//  sys_clk        in   1      system clock
//  rst            in   1      synchronous reset, active-high
//  power          in   1      car powered
//  global_state   in   2      mode; 2'b01 or 2'b10 = semi-auto, other values = inactive
//  detector       in   DET_W  line/obstacle detector bits
//  turn_left      in   1      user command, level; rising edge is the event
//  turn_right     in   1      user command, level; rising edge is the event
//  go_straight    in   1      user command, level; rising edge is the event
//  go_back        in   1      user command, level; rising edge = U-turn
//  state          out  3      FSM state: 0 MOVE, 1 WAIT, 2 TURN, 3 COOL, 4 IDLE
//  moving_state   out  4      0001 fwd, 0000 stop, 0100 left, 1000 right
//  move_forward_light / move_backward_light / turn_left_light / turn_right_light  out 1 each
// BEHAVIOUR
//  - crossroad = |((detector ^ DET_IDLE) & DET_MASK), combinational.
//  - active = power & (global_state==01 | global_state==10).
//  - Reset or !active: state=IDLE, moving_state=0000, all lights 0, counters 0, edge regs
//    take the current command levels so a held button does not fire on entry.
//  - IDLE -> MOVE on the first cycle active=1.
//  - MOVE: moving_state=0001, fwd light on. crossroad=1 -> WAIT next cycle.
//  - WAIT: moving_state=0000, all lights off. Edge events are sampled only here.
//    Priority when simultaneous: go_back > turn_left > turn_right > go_straight.
//    left/right -> TURN with cnt=TURN_CYC-1. back -> TURN with cnt=2*TURN_CYC-1
//    and direction right. straight -> COOL with cnt=COOL_CYC-1.
//  - TURN: moving_state=0100 (left) or 1000 (right), matching turn light on
//    (back also lights move_backward_light). Decrement each cycle. At cnt==0 -> COOL,
//    cnt=COOL_CYC-1. Turn duration is exactly TURN_CYC (or 2*TURN_CYC) cycles.
//  - COOL: moving_state=0001, fwd light on, crossroad ignored. At cnt==0 -> MOVE.
//  - Edges arriving outside WAIT are discarded, not queued.
//  - Outputs are registered: they change 1 cycle after the causing input edge.
//  - active dropping in any state -> IDLE next cycle. Rising active restarts in MOVE;
//    there is no resume of a turn.
//  - Counters never wrap: they load a non-zero value or stop at 0.
// CONFIGURATION
//  SEMIAUTO_WAIT_TIMEOUT_EN defined: in WAIT, a counter starts at WAIT_TO-1 on entry.
//    If it reaches 0 with no command, the block acts as if go_straight was pressed
//    (-> COOL). A command on the timeout cycle wins over the timeout.
//  Not defined: WAIT holds indefinitely until a command arrives. The WAIT_TO parameter
//    is unused and no timeout counter is built.
// TESTING  (TURN_CYC=4, COOL_CYC=3, WAIT_TO=6)
//  1 rst=1 for 2 cycles with power=1, gs=01 -> state=4, moving=0000. Release ->
//    MOVE, moving=0001, fwd light=1.
//  2 MOVE, detector 0110->0111 -> next cycle WAIT, moving=0000, lights 0.
//  3 WAIT, turn_left rises -> moving=0100 for exactly 4 cycles, then 0001 for 3 cycles
//    in COOL (crossroad held =1 ignored), then MOVE.
//  4 WAIT, go_back and turn_left rise together -> moving=1000 for 8 cycles,
//    back light=1 throughout.
//  5 Mid-TURN, global_state->00 -> IDLE next cycle, moving=0000. Back to 01 -> MOVE
//    with the turn not resumed. A held turn_right does not trigger a later WAIT.
//  6 With SEMIAUTO_WAIT_TIMEOUT_EN: WAIT and no input -> COOL after 6 cycles.
//    Without the macro: still WAIT after 100 cycles.

Source files
------------

// File: rtl/semiauto_nav.sv
// semiauto_nav: semi-automatic driving controller.
// Drives forward until a crossroad is seen, stops and waits for a user
// direction command, performs a timed turn (or goes straight), then runs a
// cooldown phase in which the crossroad is ignored so the car clears it.
// Optional feature macro: SEMIAUTO_WAIT_TIMEOUT_EN. When it is defined, WAIT
// falls through to "go straight" after WAIT_TO cycles without a command.
module semiauto_nav #(
    parameter int                 DET_W    = 4,
    parameter logic [DET_W-1:0]   DET_IDLE = 4'b0110,
    parameter logic [DET_W-1:0]   DET_MASK = 4'b0111,
    parameter int                 TURN_CYC = 1000,
    parameter int                 COOL_CYC = 1000,
    parameter int                 WAIT_TO  = 5000,
    parameter int                 CNT_W    = 16
) (
    input  logic             sys_clk_i,
    input  logic             rst_i,
    input  logic             power_i,
    input  logic [1:0]       global_state_i,
    input  logic [DET_W-1:0] detector_i,
    input  logic             turn_left_i,
    input  logic             turn_right_i,
    input  logic             go_straight_i,
    input  logic             go_back_i,
    output logic [2:0]       state_o,
    output logic [3:0]       moving_state_o,
    output logic             move_forward_light_o,
    output logic             move_backward_light_o,
    output logic             turn_left_light_o,
    output logic             turn_right_light_o
);

    typedef enum logic [2:0] {
        ST_MOVE = 3'd0,
        ST_WAIT = 3'd1,
        ST_TURN = 3'd2,
        ST_COOL = 3'd3,
        ST_IDLE = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] TURN_LOAD  = CNT_W'(TURN_CYC - 1);
    localparam logic [CNT_W-1:0] UTURN_LOAD = CNT_W'(2 * TURN_CYC - 1);
    localparam logic [CNT_W-1:0] COOL_LOAD  = CNT_W'(COOL_CYC - 1);
`ifdef SEMIAUTO_WAIT_TIMEOUT_EN
    localparam logic [CNT_W-1:0] WAIT_LOAD  = CNT_W'(WAIT_TO - 1);
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             right_q, right_d;
    logic             back_q, back_d;
    logic [3:0]       cmd_prev_q;
    logic [3:0]       moving_q, moving_d;
    logic             fwd_light_q, fwd_light_d;
    logic             back_light_q, back_light_d;
    logic             left_light_q, left_light_d;
    logic             right_light_q, right_light_d;

    logic             crossroad;
    logic             active;
    logic [3:0]       cmd_now;
    logic [3:0]       cmd_ev;

    assign crossroad = |((detector_i ^ DET_IDLE) & DET_MASK);
    assign active    = power_i & ((global_state_i == 2'b01) | (global_state_i == 2'b10));

    // Command bits ordered {back, left, right, straight}; an event is a rising level.
    assign cmd_now = {go_back_i, turn_left_i, turn_right_i, go_straight_i};
    assign cmd_ev  = cmd_now & ~cmd_prev_q;

    // Next-state logic: mode transitions, counter loads/decrements and turn direction.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        right_d = right_q;
        back_d  = back_q;
        if (!active) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            right_d = 1'b0;
            back_d  = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_MOVE;
                    cnt_d   = '0;
                end
                ST_MOVE: begin
                    if (crossroad) begin
                        state_d = ST_WAIT;
`ifdef SEMIAUTO_WAIT_TIMEOUT_EN
                        cnt_d   = WAIT_LOAD;
`else
                        cnt_d   = '0;
`endif
                    end
                end
                ST_WAIT: begin
                    if (cmd_ev[3]) begin
                        state_d = ST_TURN;
                        cnt_d   = UTURN_LOAD;
                        right_d = 1'b1;
                        back_d  = 1'b1;
                    end else if (cmd_ev[2]) begin
                        state_d = ST_TURN;
                        cnt_d   = TURN_LOAD;
                        right_d = 1'b0;
                        back_d  = 1'b0;
                    end else if (cmd_ev[1]) begin
                        state_d = ST_TURN;
                        cnt_d   = TURN_LOAD;
                        right_d = 1'b1;
                        back_d  = 1'b0;
                    end else if (cmd_ev[0]) begin
                        state_d = ST_COOL;
                        cnt_d   = COOL_LOAD;
                    end
`ifdef SEMIAUTO_WAIT_TIMEOUT_EN
                    else if (cnt_q == '0) begin
                        state_d = ST_COOL;
                        cnt_d   = COOL_LOAD;
                    end else begin
                        cnt_d   = cnt_q - 1'b1;
                    end
`endif
                end
                ST_TURN: begin
                    if (cnt_q == '0) begin
                        state_d = ST_COOL;
                        cnt_d   = COOL_LOAD;
                        back_d  = 1'b0;
                    end else begin
                        cnt_d   = cnt_q - 1'b1;
                    end
                end
                ST_COOL: begin
                    if (cnt_q == '0) begin
                        state_d = ST_MOVE;
                    end else begin
                        cnt_d   = cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Output decode from the next state so motor and lights are registered with it.
    always_comb begin
        moving_d      = 4'b0000;
        fwd_light_d   = 1'b0;
        back_light_d  = 1'b0;
        left_light_d  = 1'b0;
        right_light_d = 1'b0;
        unique case (state_d)
            ST_MOVE, ST_COOL: begin
                moving_d    = 4'b0001;
                fwd_light_d = 1'b1;
            end
            ST_TURN: begin
                back_light_d = back_d;
                if (right_d) begin
                    moving_d      = 4'b1000;
                    right_light_d = 1'b1;
                end else begin
                    moving_d      = 4'b0100;
                    left_light_d  = 1'b1;
                end
            end
            default: begin
                moving_d = 4'b0000;
            end
        endcase
    end

    // State, counter, outputs and command history; history always tracks levels so held buttons never fire.
    always_ff @(posedge sys_clk_i) begin
        cmd_prev_q <= cmd_now;
        if (rst_i) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            right_q       <= 1'b0;
            back_q        <= 1'b0;
            moving_q      <= 4'b0000;
            fwd_light_q   <= 1'b0;
            back_light_q  <= 1'b0;
            left_light_q  <= 1'b0;
            right_light_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            right_q       <= right_d;
            back_q        <= back_d;
            moving_q      <= moving_d;
            fwd_light_q   <= fwd_light_d;
            back_light_q  <= back_light_d;
            left_light_q  <= left_light_d;
            right_light_q <= right_light_d;
        end
    end

    assign state_o               = state_q;
    assign moving_state_o        = moving_q;
    assign move_forward_light_o  = fwd_light_q;
    assign move_backward_light_o = back_light_q;
    assign turn_left_light_o     = left_light_q;
    assign turn_right_light_o    = right_light_q;

endmodule
